// File: rtl/sh_mem_banked_if.sv
// Flattened per-port request/response bundle between the cores and the banked shared memory.
interface sh_mem_banked_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8
);
  logic [2*NUM_PORTS-1:0]      enable_arb;
  logic [ADDR_W*NUM_PORTS-1:0] addr_arb;
  logic [DATA_W*NUM_PORTS-1:0] wr_data_arb;
  logic [DATA_W*NUM_PORTS-1:0] rd_data_arb;
  logic [NUM_PORTS-1:0]        ready_arb;

  modport master (
    output enable_arb, addr_arb, wr_data_arb,
    input  rd_data_arb, ready_arb
  );

  modport slave (
    input  enable_arb, addr_arb, wr_data_arb,
    output rd_data_arb, ready_arb
  );
endinterface

// File: rtl/sh_mem_banked.sv
// Multi-bank shared memory: per-bank round-robin arbitration over NUM_PORTS cores,
// read-before-write single-port banks, registered one-cycle ready pulse per port.
module sh_mem_banked #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BANK_BITS = 2
) (
  input logic            clk,
  input logic            reset,
  sh_mem_banked_if.slave bus
);

  localparam int unsigned NUM_BANKS = 1 << BANK_BITS;
  localparam int unsigned BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
  localparam int unsigned DEPTH     = 1 << ROW_W;
  localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

  logic [PTR_W-1:0]  ptr_q     [NUM_BANKS];
  logic [PTR_W-1:0]  ptr_d     [NUM_BANKS];
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic [NUM_PORTS-1:0] ready_q, ready_d;
  logic [DATA_W-1:0] rd_data_q [NUM_PORTS];
  logic [DATA_W-1:0] rd_data_d [NUM_PORTS];

  logic [1:0]        en   [NUM_PORTS];
  logic [ADDR_W-1:0] addr [NUM_PORTS];
  logic [DATA_W-1:0] wdat [NUM_PORTS];
  logic [BSEL_W-1:0] bsel [NUM_PORTS];
  logic [ROW_W-1:0]  row  [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] gnt;

  logic              bank_we   [NUM_BANKS];
  logic [ROW_W-1:0]  bank_row  [NUM_BANKS];
  logic [DATA_W-1:0] bank_wdat [NUM_BANKS];

  // Unpack per-port request fields; a port just granted is masked for one cycle.
  always_comb begin
    elig = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      en[p]   = bus.enable_arb[2*p +: 2];
      addr[p] = bus.addr_arb[ADDR_W*p +: ADDR_W];
      wdat[p] = bus.wr_data_arb[DATA_W*p +: DATA_W];
      bsel[p] = BSEL_W'(addr[p] & ADDR_W'(NUM_BANKS - 1));
      row[p]  = ROW_W'(addr[p] >> BANK_BITS);
      elig[p] = ((en[p] == 2'b01) || (en[p] == 2'b10)) && !mask_q[p];
    end
  end

  // Per-bank cyclic search from the pointer; winner drives the bank access.
  always_comb begin
    logic        found;
    int unsigned win;
    int unsigned idx;
    gnt   = '0;
    ptr_d = ptr_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) rd_data_d[p] = rd_data_q[p];
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]   = 1'b0;
      bank_row[b]  = '0;
      bank_wdat[b] = '0;
      found = 1'b0;
      win   = 0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = 32'(ptr_q[b]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && elig[idx] && (32'(bsel[idx]) == b)) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found) begin
        gnt[win]       = 1'b1;
        ptr_d[b]       = (win == NUM_PORTS - 1) ? '0 : PTR_W'(win + 1);
        bank_we[b]     = (en[win] == 2'b10);
        bank_row[b]    = row[win];
        bank_wdat[b]   = wdat[win];
        rd_data_d[win] = mem[b][row[win]];
      end
    end
  end

  assign ready_d = gnt;
  assign mask_d  = gnt;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_we[b]) mem[b][bank_row[b]] <= bank_wdat[b];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= '0;
      mask_q  <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) rd_data_q[p] <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
    end else begin
      ready_q <= ready_d;
      mask_q  <= mask_d;
      for (int unsigned p = 0; p < NUM_PORTS; p++) rd_data_q[p] <= rd_data_d[p];
      for (int unsigned b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bus.rd_data_arb[DATA_W*p +: DATA_W] = rd_data_q[p];
    end
  end

  assign bus.ready_arb = ready_q;

endmodule
